axi4_lite_regfile_slave: RTL

Parametrised AXI4-Lite slave register file, successor to the fixed 32-bit slave top. Generalises data width and register count; adds independent AW/W acceptance in either order, WSTRB byte masking, per-register read-only protection and SLVERR responses for illegal accesses. Sits behind the AXI4-Lite interconnect as the control/status register block of a peripheral, one outstanding write and one outstanding read.

---
 rtl/axi4_lite_regfile_slave_if.sv | 40 ++++
 rtl/axi4_lite_regfile_slave.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/axi4_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle for the register-file slave: all five channels,
// with modports for the interconnect (master) and the register block (slave).
interface axi4_lite_regfile_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] S_AWADDR;
    logic                  S_AWVALID;
    logic                  S_AWREADY;
    logic [DATA_WIDTH-1:0] S_WDATA;
    logic [STRB_WIDTH-1:0] S_WSTRB;
    logic                  S_WVALID;
    logic                  S_WREADY;
    logic [1:0]            S_BRESP;
    logic                  S_BVALID;
    logic                  S_BREADY;
    logic [ADDR_WIDTH-1:0] S_ARADDR;
    logic                  S_ARVALID;
    logic                  S_ARREADY;
    logic [DATA_WIDTH-1:0] S_RDATA;
    logic [1:0]            S_RRESP;
    logic                  S_RVALID;
    logic                  S_RREADY;

    modport master (
        output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
               S_ARREADY, S_RDATA, S_RRESP, S_RVALID
    );

    modport slave (
        input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
               S_ARADDR, S_ARVALID, S_RREADY,
        output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
               S_ARREADY, S_RDATA, S_RRESP, S_RVALID
    );
endinterface

// File: rtl/axi4_lite_regfile_slave.sv
// Parametrised AXI4-Lite control/status register file: one outstanding write
// (AW/W in any order, byte strobes, read-only protection) and one outstanding read.
module axi4_lite_regfile_slave #(
    parameter int unsigned         ADDR_WIDTH = 32,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    axi4_lite_regfile_slave_if.slave    s_axi
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH  = $clog2(NUM_REGS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Write-path state
    logic                  aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  awready_q, wready_q;

    // Read-path state
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  arready_q;

    // Next-state values
    logic                  aw_held_n, w_held_n, bvalid_n, awready_n, wready_n;
    logic [1:0]            bresp_n;
    logic                  rvalid_n, arready_n;
    logic [1:0]            rresp_n;
    logic [DATA_WIDTH-1:0] rdata_n;

    logic                  aw_hs_c, w_hs_c, ar_hs_c, commit_c;
    logic                  wr_in_range_c, wr_ok_c, rd_in_range_c;
    logic [IDX_WIDTH-1:0]  wr_idx_c, rd_idx_c;

    // Address decode; ready flags are registered so handshakes see only flop outputs
    always_comb begin
        aw_hs_c       = s_axi.S_AWVALID && awready_q;
        w_hs_c        = s_axi.S_WVALID  && wready_q;
        ar_hs_c       = s_axi.S_ARVALID && arready_q;
        commit_c      = aw_held_q && w_held_q;
        wr_in_range_c = (aw_addr_q >> ADDR_LSB) < NUM_REGS_A;
        wr_idx_c      = IDX_WIDTH'(aw_addr_q >> ADDR_LSB);
        wr_ok_c       = wr_in_range_c && !RO_MASK[wr_idx_c];
        rd_in_range_c = (s_axi.S_ARADDR >> ADDR_LSB) < NUM_REGS_A;
        rd_idx_c      = IDX_WIDTH'(s_axi.S_ARADDR >> ADDR_LSB);
    end

    // Write-path next state: a commit always clears both holds and raises BVALID
    always_comb begin
        aw_held_n = aw_held_q;
        w_held_n  = w_held_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        if (commit_c) begin
            aw_held_n = 1'b0;
            w_held_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs_c) aw_held_n = 1'b1;
            if (w_hs_c)  w_held_n  = 1'b1;
            if (bvalid_q && s_axi.S_BREADY) bvalid_n = 1'b0;
        end
        awready_n = !aw_held_n && !bvalid_n;
        wready_n  = !w_held_n  && !bvalid_n;
    end

    // Read-path next state
    always_comb begin
        rvalid_n = rvalid_q;
        rresp_n  = rresp_q;
        rdata_n  = rdata_q;
        if (ar_hs_c) begin
            rvalid_n = 1'b1;
            rresp_n  = rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
            rdata_n  = rd_in_range_c ? regs[rd_idx_c] : '0;
        end else if (rvalid_q && s_axi.S_RREADY) begin
            rvalid_n = 1'b0;
        end
        arready_n = !rvalid_n;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
        end else begin
            if (aw_hs_c) aw_addr_q <= s_axi.S_AWADDR;
            if (w_hs_c) begin
                w_data_q <= s_axi.S_WDATA;
                w_strb_q <= s_axi.S_WSTRB;
            end
            aw_held_q <= aw_held_n;
            w_held_q  <= w_held_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            arready_q <= 1'b1;
        end else begin
            rvalid_q  <= rvalid_n;
            rresp_q   <= rresp_n;
            rdata_q   <= rdata_n;
            arready_q <= arready_n;
        end
    end

    // Register storage: byte-masked update on a legal commit
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit_c && wr_ok_c) begin
            for (int unsigned k = 0; k < STRB_WIDTH; k++) begin
                if (w_strb_q[k]) regs[wr_idx_c][8*k +: 8] <= w_data_q[8*k +: 8];
            end
        end
    end

    assign s_axi.S_AWREADY = awready_q;
    assign s_axi.S_WREADY  = wready_q;
    assign s_axi.S_BVALID  = bvalid_q;
    assign s_axi.S_BRESP   = bresp_q;
    assign s_axi.S_ARREADY = arready_q;
    assign s_axi.S_RVALID  = rvalid_q;
    assign s_axi.S_RRESP   = rresp_q;
    assign s_axi.S_RDATA   = rdata_q;
endmodule
